// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types and constants for the LSU stage: FSM states, func3 access codes, error codes.
package ysyx_24110015_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Byte accesses are never misaligned; halfwords need bit 0 clear, words both bits clear.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24110015_load_ext.sv
// Load data extraction: selects the addressed byte/halfword of a bus word and extends it.
module ysyx_24110015_load_ext
  import ysyx_24110015_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign or zero extension.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext_data = {24'h000000, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext_data = {16'h0000, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// LSU stage: accepts one EXU packet, issues at most one memory request, returns a WB packet.
// Store lanes are aligned on accept; load data is extracted when the response arrives.
module ysyx_24110015_lsu
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic [2:0]  func3,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        zicsr,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] pc_next_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic        RegWrite_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] pc_next_o,
  output logic [1:0]  lsu_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_t    state_r, state_nx;
  logic [CW-1:0] cnt_r;
  logic          stale_r, is_load_r;
  logic [2:0]    func3_r;
  logic [1:0]    off_r;
  logic          accept, is_mem, misaligned, busy, timeout, timeout_hit, rsp_take;
  logic [31:0]   ext_data;

  assign in_ready    = (state_r == S_IDLE);
  assign out_valid   = (state_r == S_DONE);
  assign req_valid   = (state_r == S_REQ);
  assign accept      = in_ready && in_valid;
  assign is_mem      = MemRead || MemWrite;
  assign misaligned  = is_mem && is_misaligned(func3, alu_out[1:0]);
  assign busy        = (state_r == S_REQ) || (state_r == S_WAIT);
  assign timeout     = (TIMEOUT_CYC != 0) && busy && (cnt_r == CNT_LAST);
  // A response arriving on the last allowed cycle still wins over the timeout.
  assign rsp_take    = (state_r == S_WAIT) && rsp_valid && !stale_r;
  assign timeout_hit = timeout && !rsp_take;

  ysyx_24110015_load_ext u_load_ext (
    .rdata    (rsp_rdata),
    .offset   (off_r),
    .func3    (func3_r),
    .ext_data (ext_data)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_nx = (is_mem && !misaligned) ? S_REQ : S_DONE;
        else          state_nx = S_IDLE;
      end
      S_REQ: begin
        if (timeout)        state_nx = S_DONE;
        else if (req_ready) state_nx = S_WAIT;
        else                state_nx = S_REQ;
      end
      S_WAIT: begin
        if (rsp_take || timeout) state_nx = S_DONE;
        else                     state_nx = S_WAIT;
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
        else           state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state: FSM, timeout counter and the orphaned-response marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      stale_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (accept)    cnt_r <= '0;
      else if (busy) cnt_r <= cnt_r + CW'(1);
      // An abandoned request that the bus already took will still answer once; drop it.
      if (timeout_hit && ((state_r == S_WAIT) || req_ready)) stale_r <= 1'b1;
      else if (rsp_valid)                                    stale_r <= 1'b0;
    end
  end

  // Packet registers: captured on accept, updated by load response or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_r  <= 1'b0;
      func3_r    <= 3'b000;
      off_r      <= 2'b00;
      wb_data    <= 32'h0000_0000;
      RegWrite_o <= 1'b0;
      wb_addr_o  <= 5'd0;
      pc_next_o  <= 32'h0000_0000;
      lsu_err    <= ERR_OK;
      req_wen    <= 1'b0;
      req_addr   <= 32'h0000_0000;
      req_wdata  <= 32'h0000_0000;
      req_wstrb  <= 4'b0000;
    end else if (accept) begin
      is_load_r  <= MemRead && !MemWrite;
      func3_r    <= func3;
      off_r      <= alu_out[1:0];
      wb_data    <= (!is_mem && zicsr) ? csr_rdata : alu_out;
      RegWrite_o <= RegWrite_i && !misaligned;
      wb_addr_o  <= wb_addr_i;
      pc_next_o  <= pc_next_i;
      lsu_err    <= misaligned ? ERR_MISALIGN : ERR_OK;
      req_wen    <= MemWrite;
      req_addr   <= {alu_out[31:2], 2'b00};
      req_wdata  <= mem_wdata << {alu_out[1:0], 3'b000};
      req_wstrb  <= MemWrite ? (mem_wmask << alu_out[1:0]) : 4'b0000;
    end else if (rsp_take) begin
      if (is_load_r) wb_data <= ext_data;
    end else if (timeout_hit) begin
      lsu_err    <= ERR_TIMEOUT;
      RegWrite_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Self-checking bench for ysyx_24110015_lsu: directed vector table, randomized packets against
// an arithmetic reference model, and hand sequences for timeout, reset and output back-pressure.
module tb_ysyx_24110015_lsu;

  typedef struct {
    logic [31:0] alu, wdata, csr, rdata;
    logic [3:0]  wmask;
    logic [2:0]  f3;
    logic        mr, mw, rw, zicsr;
    int          stall, wt;
  } stim_t;

  typedef struct {
    logic        bus, wen, rw;
    logic [31:0] addr, wdata, wb;
    logic [3:0]  wstrb;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, req_ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] alu_out = '0, mem_wdata = '0, csr_rdata = '0, pc_next_i = '0, rsp_rdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic [2:0]  func3 = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write_i = 1'b0, zicsr = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic        in_ready, out_valid, reg_write_o, req_valid, req_wen;
  logic [31:0] wb_data, pc_next_o, req_addr, req_wdata;
  logic [4:0]  wb_addr_o;
  logic [1:0]  lsu_err;
  logic [3:0]  req_wstrb;
  // Second instance with a short timeout; shares data inputs, owns its handshakes.
  logic        t_in_valid = 1'b0, t_out_ready = 1'b1, t_req_ready = 1'b0, t_rsp_valid = 1'b0;
  logic        t_in_ready, t_out_valid, t_reg_write_o, t_req_valid, t_req_wen;
  logic [31:0] t_wb_data, t_pc_next_o, t_req_addr, t_req_wdata;
  logic [4:0]  t_wb_addr_o;
  logic [1:0]  t_lsu_err;
  logic [3:0]  t_req_wstrb;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24110015_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .func3(func3), .MemRead(mem_read),
    .MemWrite(mem_write), .RegWrite_i(reg_write_i), .wb_addr_i(wb_addr_i), .zicsr(zicsr),
    .csr_rdata(csr_rdata), .pc_next_i(pc_next_i), .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .RegWrite_o(reg_write_o), .wb_addr_o(wb_addr_o), .pc_next_o(pc_next_o),
    .lsu_err(lsu_err), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata)
  );

  ysyx_24110015_lsu #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .alu_out(alu_out),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .func3(func3), .MemRead(mem_read),
    .MemWrite(mem_write), .RegWrite_i(reg_write_i), .wb_addr_i(wb_addr_i), .zicsr(zicsr),
    .csr_rdata(csr_rdata), .pc_next_i(pc_next_i), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .wb_data(t_wb_data), .RegWrite_o(t_reg_write_o), .wb_addr_o(t_wb_addr_o), .pc_next_o(t_pc_next_o),
    .lsu_err(t_lsu_err), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_wen(t_req_wen),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_wstrb(t_req_wstrb), .rsp_valid(t_rsp_valid),
    .rsp_rdata(rsp_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] alu, wdata, input logic [3:0] wmask,
                              input logic [2:0] f3, input logic mr, mw, rw, z,
                              input logic [31:0] csr, rdata, input int stall, wt,
                              input logic bus, wen, input logic [31:0] addr, ewdata,
                              input logic [3:0] wstrb, input logic [31:0] wb,
                              input logic erw, input logic [1:0] err);
    vec_t v;
    v.s = '{alu: alu, wdata: wdata, csr: csr, rdata: rdata, wmask: wmask, f3: f3,
            mr: mr, mw: mw, rw: rw, zicsr: z, stall: stall, wt: wt};
    v.e = '{bus: bus, wen: wen, rw: erw, addr: addr, wdata: ewdata, wb: wb, wstrb: wstrb, err: err};
    return v;
  endfunction

  // Reference: plain arithmetic on byte offset and access size.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int unsigned o, size;
    logic [31:0] v;
    logic mis;
    o = s.alu % 4;
    case (s.f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    mis     = (s.mr || s.mw) && ((s.alu % size) != 0);
    e.bus   = (s.mr || s.mw) && !mis;
    e.wen   = s.mw;
    e.addr  = s.alu - o;
    e.wdata = s.wdata << (8 * o);
    e.wstrb = 4'(s.mw ? (32'(s.wmask) << o) : 32'd0);
    e.err   = mis ? 2'b01 : 2'b00;
    e.rw    = s.rw && !mis;
    if (s.mr && !s.mw) begin
      case (s.f3)
        3'd0, 3'd4: begin
          v = (s.rdata >> (8 * o)) % 256;
          if (s.f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end
        3'd1, 3'd5: begin
          v = (s.rdata >> (16 * (o / 2))) % 65536;
          if (s.f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        default: v = s.rdata;
      endcase
      e.wb = v;
    end else if (!s.mr && !s.mw && s.zicsr) e.wb = s.csr;
    else e.wb = s.alu;
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int kind;
    kind = $urandom_range(0, 2);
    s.alu = $urandom; s.wdata = $urandom; s.csr = $urandom; s.rdata = $urandom;
    s.rw = 1'b1; s.zicsr = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.wmask = 4'b0001;
    s.f3 = 3'($urandom_range(0, 7));
    s.stall = $urandom_range(0, 3);
    s.wt = $urandom_range(0, 3);
    if ($urandom_range(0, 1) == 1) s.alu = s.alu & 32'hFFFF_FFFC;
    case (kind)
      0: s.zicsr = 1'($urandom_range(0, 1));
      1: begin
        s.mr = 1'b1;
        case ($urandom_range(0, 4))
          0: s.f3 = 3'd0;
          1: s.f3 = 3'd1;
          2: s.f3 = 3'd2;
          3: s.f3 = 3'd4;
          default: s.f3 = 3'd5;
        endcase
      end
      default: begin
        s.mw = 1'b1;
        s.mr = 1'($urandom_range(0, 1));
        s.rw = 1'b0;
        s.f3 = 3'($urandom_range(0, 2));
        s.wmask = (s.f3 == 3'd0) ? 4'b0001 : (s.f3 == 3'd1) ? 4'b0011 : 4'b1111;
      end
    endcase
    return s;
  endfunction

  task automatic drive_in(input stim_t s);
    alu_out = s.alu; mem_wdata = s.wdata; mem_wmask = s.wmask; func3 = s.f3;
    mem_read = s.mr; mem_write = s.mw; reg_write_i = s.rw; zicsr = s.zicsr; csr_rdata = s.csr;
  endtask

  // One packet through the main instance; stall/wait shape the bus handshake.
  task automatic run_txn(input string tag, input stim_t s, input exp_t e);
    logic [4:0]  rd;
    logic [31:0] pc;
    int n;
    rd = 5'($urandom_range(0, 31));
    pc = $urandom;
    drive_in(s);
    wb_addr_i = rd; pc_next_i = pc;
    in_valid = 1'b1; out_ready = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    if (e.bus) begin
      for (int k = 0; k <= s.stall; k++) begin
        chk({tag, ".req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, ".req_addr"}, req_addr, e.addr);
        chk({tag, ".req_wdata"}, req_wdata, e.wdata);
        chk({tag, ".req_wstrb"}, 32'(req_wstrb), 32'(e.wstrb));
        chk({tag, ".req_wen"}, 32'(req_wen), 32'(e.wen));
        if (k == s.stall) req_ready = 1'b1;
        tick();
      end
      req_ready = 1'b0;
      chk({tag, ".req_drop"}, 32'(req_valid), 32'd0);
      for (int k = 0; k < s.wt; k++) tick();
      rsp_valid = 1'b1; rsp_rdata = s.rdata;
      tick();
      rsp_valid = 1'b0; rsp_rdata = $urandom;
    end else begin
      chk({tag, ".no_req"}, 32'(req_valid), 32'd0);
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    if (e.err == 2'b00) chk({tag, ".wb_data"}, wb_data, e.wb);
    chk({tag, ".regwrite"}, 32'(reg_write_o), 32'(e.rw));
    chk({tag, ".lsu_err"}, 32'(lsu_err), 32'(e.err));
    chk({tag, ".wb_addr"}, 32'(wb_addr_o), 32'(rd));
    chk({tag, ".pc_next"}, pc_next_o, pc);
    tick();
    chk({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      rst = 1'b1; tick(); rst = 1'b0;
    end
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    stim_t s;
    logic [31:0] held;

    tbl[0]  = mk(32'h0000_1234, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_1234, 1'b1, 2'b00);
    tbl[1]  = mk(32'h8000_0003, 32'h0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80FF_0000, 0, 1,
                 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b1, 2'b00);
    tbl[2]  = mk(32'h8000_0003, 32'h0, 4'h0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80FF_0000, 1, 0,
                 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0080, 1'b1, 2'b00);
    tbl[3]  = mk(32'h8000_0002, 32'h0000_BEEF, 4'b0011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3, 0,
                 1'b1, 1'b1, 32'h8000_0000, 32'hBEEF_0000, 4'b1100, 32'h8000_0002, 1'b0, 2'b00);
    tbl[4]  = mk(32'h8000_0006, 32'h0, 4'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b01);
    tbl[5]  = mk(32'h0000_0010, 32'h0, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_DEAD, 32'h0, 0, 0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_DEAD, 1'b1, 2'b00);
    tbl[6]  = mk(32'h0000_0101, 32'h0000_00AB, 4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1, 2,
                 1'b1, 1'b1, 32'h0000_0100, 32'h0000_AB00, 4'b0010, 32'h0000_0101, 1'b0, 2'b00);
    tbl[7]  = mk(32'h0000_2002, 32'h0, 4'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8001_1234, 0, 0,
                 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'hFFFF_8001, 1'b1, 2'b00);
    tbl[8]  = mk(32'h0000_2002, 32'h0, 4'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8001_1234, 2, 3,
                 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0000_8001, 1'b1, 2'b00);
    tbl[9]  = mk(32'h0000_0100, 32'h1122_3344, 4'hF, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1,
                 1'b1, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0000_0100, 1'b0, 2'b00);
    tbl[10] = mk(32'h0000_0300, 32'h0, 4'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 0, 0,
                 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 2'b00);
    tbl[11] = mk(32'h0000_0001, 32'h0, 4'b0011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0,
                 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2'b01);

    // Reset state.
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.req_valid", 32'(req_valid), 32'd0);
    chk("rst.regwrite", 32'(reg_write_o), 32'd0);
    chk("rst.lsu_err", 32'(lsu_err), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.req_addr", req_addr, 32'd0);
    chk("rst.req_wstrb", 32'(req_wstrb), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);

    for (int i = 0; i < 40; i++) begin
      s = rand_stim();
      run_txn($sformatf("rnd%0d", i), s, model(s));
    end

    // Output back-pressure: DONE holds its packet and refuses new input.
    s = rand_stim();
    s.mr = 1'b0; s.mw = 1'b0; s.zicsr = 1'b0;
    drive_in(s);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    held = s.alu;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      tick();
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.wb_data", wb_data, held);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("hold.release", 32'(in_ready), 32'd1);

    // Reset while waiting for a load response.
    s.alu = 32'h0000_0400; s.f3 = 3'd2; s.mr = 1'b1; s.mw = 1'b0; s.rw = 1'b1;
    drive_in(s);
    in_valid = 1'b1; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    req_ready = 1'b0;
    chk("rstw.in_wait", 32'(req_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw.req_valid", 32'(req_valid), 32'd0);
    chk("rstw.out_valid", 32'(out_valid), 32'd0);
    chk("rstw.in_ready", 32'(in_ready), 32'd1);
    chk("rstw.regwrite", 32'(reg_write_o), 32'd0);
    chk("rstw.pc_next", pc_next_o, 32'd0);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("rstw.late_rsp", 32'(out_valid), 32'd0);
    chk("rstw.late_idle", 32'(in_ready), 32'd1);

    // Timeout with the request never accepted, then with the response never arriving.
    for (int m = 0; m < 2; m++) begin
      s.alu = 32'h8000_0000; s.f3 = 3'd2; s.mr = 1'b1; s.mw = 1'b0; s.rw = 1'b1;
      drive_in(s);
      t_in_valid = 1'b1; t_req_ready = (m == 1);
      tick();
      t_in_valid = 1'b0;
      n = 0;
      while (!t_out_valid && n < 20) begin tick(); n++; end
      chk($sformatf("to%0d.cycles", m), 32'(n), 32'd4);
      chk($sformatf("to%0d.lsu_err", m), 32'(t_lsu_err), 32'd2);
      chk($sformatf("to%0d.regwrite", m), 32'(t_reg_write_o), 32'd0);
      chk($sformatf("to%0d.req_valid", m), 32'(t_req_valid), 32'd0);
      t_req_ready = 1'b0;
      tick();
      chk($sformatf("to%0d.idle", m), 32'(t_in_ready), 32'd1);
    end
    t_rsp_valid = 1'b1; rsp_rdata = 32'hAAAA_AAAA;
    tick();
    t_rsp_valid = 1'b0;
    chk("to.late_rsp_valid", 32'(t_out_valid), 32'd0);
    chk("to.late_rsp_idle", 32'(t_in_ready), 32'd1);

    // Three cycles in REQ/WAIT stays under the 4-cycle limit.
    t_in_valid = 1'b1; t_req_ready = 1'b1;
    tick();
    t_in_valid = 1'b0;
    tick();
    t_req_ready = 1'b0;
    tick();
    t_rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D;
    tick();
    t_rsp_valid = 1'b0;
    chk("to.ok_valid", 32'(t_out_valid), 32'd1);
    chk("to.ok_err", 32'(t_lsu_err), 32'd0);
    chk("to.ok_wb", t_wb_data, 32'hCAFE_F00D);
    chk("to.ok_regwrite", 32'(t_reg_write_o), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
